// File: rtl/demand_detector_pkg.sv
// Shared definitions for the loop-detector front end: light colours, boolean
// constants, per-channel call states and a small saturating-increment helper.
package demand_detector_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        FLASH  = 2'd3
    } color;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMING  = 2'd1,
        DEMAND  = 2'd2,
        SERVING = 2'd3
    } chan_state_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

endpackage

// File: rtl/demand_detector_channel.sv
// One detector channel: debounces its loop, latches a call and releases it once served.
// Optional stuck-loop detection is built when STUCK_DETECT_EN is defined.
module demand_channel
    import demand_detector_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 2,
    parameter int MIN_SERVE    = 3,
    parameter int STUCK_CYC    = 240
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Loop,
    input  color L,
    output logic S,
    output logic Fault
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE_CYC);
    localparam logic [3:0] MS  = 4'(MIN_SERVE);

    chan_state_t state;
    logic [3:0]  dcnt;
    logic [3:0]  scnt;
    logic [3:0]  scnt_inc;
    logic        stuck_nxt;

    assign scnt_inc = sat_inc4(scnt, MS);

`ifdef STUCK_DETECT_EN
    logic [7:0] run;
    logic [7:0] run_inc;

    assign run_inc   = (run == 8'hFF) ? run : run + 8'd1;
    // Fault holds only while the loop stays high; a single low sample clears it.
    assign stuck_nxt = Loop && (Fault || (int'(run_inc) >= STUCK_CYC));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            run   <= 8'd0;
            Fault <= FALSE;
        end else begin
            run   <= Loop ? run_inc : 8'd0;
            Fault <= stuck_nxt;
        end
    end
`else
    assign stuck_nxt = FALSE;
    assign Fault     = FALSE;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            dcnt  <= 4'd0;
            scnt  <= 4'd0;
            S     <= FALSE;
        end else if (L == FLASH) begin
            state <= IDLE;
            dcnt  <= 4'd0;
            scnt  <= 4'd0;
            S     <= FALSE;
        end else begin
            // Default output tracks the current call; transitions below override it.
            S <= stuck_nxt | (state == DEMAND) | (state == SERVING);
            case (state)
                IDLE: begin
                    if (Loop) begin
                        if (DEB == 4'd1) begin
                            state <= DEMAND;
                            S     <= TRUE;
                        end else begin
                            state <= ARMING;
                            dcnt  <= 4'd1;
                        end
                    end
                end
                ARMING: begin
                    if (!Loop) begin
                        state <= IDLE;
                        dcnt  <= 4'd0;
                    end else if (dcnt + 4'd1 == DEB) begin
                        state <= DEMAND;
                        dcnt  <= 4'd0;
                        S     <= TRUE;
                    end else begin
                        dcnt <= dcnt + 4'd1;
                    end
                end
                DEMAND: begin
                    if (L == GREEN) begin
                        state <= SERVING;
                        scnt  <= 4'd1;
                    end
                end
                SERVING: begin
                    if (L == GREEN) begin
                        if (scnt_inc == MS && !Loop) begin
                            state <= IDLE;
                            scnt  <= 4'd0;
                            S     <= stuck_nxt;
                        end else begin
                            scnt <= scnt_inc;
                        end
                    end else if (scnt < MS || Loop) begin
                        // Green ended too early or traffic is still waiting: re-call.
                        state <= DEMAND;
                        scnt  <= 4'd0;
                    end else begin
                        state <= IDLE;
                        scnt  <= 4'd0;
                        S     <= stuck_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/demand_detector.sv
// Three-channel loop-detector front end producing the controller's S1..S3 calls.
// Define STUCK_DETECT_EN to build per-channel stuck-loop detection (Fault outputs).
module demand_detector
    import demand_detector_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 2,
    parameter int MIN_SERVE    = 3,
    parameter int STUCK_CYC    = 240
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Loop1,
    input  logic       Loop2,
    input  logic       Loop3,
    input  color       L1,
    input  color       L2,
    input  color       L3,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    output logic [2:0] Fault
);

    // Channel 1 is 4th Ave; channels 2 and 3 are the Harrison approaches.
    demand_channel #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .MIN_SERVE   (MIN_SERVE),
        .STUCK_CYC   (STUCK_CYC)
    ) u_ch1 (
        .Clock(Clock),
        .Reset(Reset),
        .Loop (Loop1),
        .L    (L1),
        .S    (S1),
        .Fault(Fault[0])
    );

    demand_channel #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .MIN_SERVE   (MIN_SERVE),
        .STUCK_CYC   (STUCK_CYC)
    ) u_ch2 (
        .Clock(Clock),
        .Reset(Reset),
        .Loop (Loop2),
        .L    (L2),
        .S    (S2),
        .Fault(Fault[1])
    );

    demand_channel #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .MIN_SERVE   (MIN_SERVE),
        .STUCK_CYC   (STUCK_CYC)
    ) u_ch3 (
        .Clock(Clock),
        .Reset(Reset),
        .Loop (Loop3),
        .L    (L3),
        .S    (S3),
        .Fault(Fault[2])
    );

endmodule

// File: tb/tb_demand_detector.sv
// Bench for demand_detector: directed vector table, hand sequences for FLASH,
// async reset and stuck loops, then random traffic against a behavioural model.
module tb_demand_detector;
    import demand_detector_pkg::*;

    localparam int DEB = 2;
    localparam int MS  = 3;
    localparam int STK = 10;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Loop1, Loop2, Loop3;
    color       L1, L2, L3;
    logic       S1, S2, S3;
    logic [2:0] Fault;

    int checks = 0;
    int fails  = 0;

    always #5 Clock = ~Clock;

    demand_detector #(
        .DEBOUNCE_CYC(DEB),
        .MIN_SERVE   (MS),
        .STUCK_CYC   (STK)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Loop1(Loop1),
        .Loop2(Loop2),
        .Loop3(Loop3),
        .L1   (L1),
        .L2   (L2),
        .L3   (L3),
        .S1   (S1),
        .S2   (S2),
        .S3   (S3),
        .Fault(Fault)
    );

    typedef struct {
        logic [2:0] loop;
        color       l1, l2, l3;
        logic [2:0] s;
    } vec_t;

    vec_t tbl [25];

    // Behavioural model state, one entry per channel
    int   hrun [3];
    int   srv  [3];
    int   stk  [3];
    bit   call [3];
    bit   fm   [3];
    bit   fl   [3];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] loop, input color a, input color b,
                                input color c, input logic [2:0] s);
        vec_t v;
        v.loop = loop; v.l1 = a; v.l2 = b; v.l3 = c; v.s = s;
        return v;
    endfunction

    task automatic apply(input logic [2:0] loop, input color a, input color b, input color c);
        Loop1 = loop[0]; Loop2 = loop[1]; Loop3 = loop[2];
        L1 = a; L2 = b; L3 = c;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            hrun[i] = 0; srv[i] = 0; stk[i] = 0; call[i] = 0; fm[i] = 0; fl[i] = 0;
        end
    endtask

    // Call bookkeeping: a call exists once DEB consecutive high samples are seen;
    // srv counts green cycles seen by that call (0 = still waiting for green).
    task automatic model_step(input int ch, input logic lp, input color lc);
        stk[ch] = lp ? stk[ch] + 1 : 0;
`ifdef STUCK_DETECT_EN
        fm[ch] = lp && (stk[ch] >= STK);
`else
        fm[ch] = 1'b0;
`endif
        fl[ch] = (lc == FLASH);
        if (lc == FLASH) begin
            call[ch] = 0; hrun[ch] = 0; srv[ch] = 0;
        end else if (!call[ch]) begin
            hrun[ch] = lp ? hrun[ch] + 1 : 0;
            if (hrun[ch] >= DEB) begin
                call[ch] = 1; hrun[ch] = 0;
            end
        end else if (srv[ch] == 0) begin
            if (lc == GREEN) srv[ch] = 1;
        end else if (lc == GREEN) begin
            if (srv[ch] < MS) srv[ch]++;
            if (srv[ch] == MS && !lp) begin
                call[ch] = 0; srv[ch] = 0;
            end
        end else begin
            if (srv[ch] < MS || lp) srv[ch] = 0;
            else begin
                call[ch] = 0; srv[ch] = 0;
            end
        end
    endtask

    function automatic color rand_color();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return FLASH;
        if (r <= 6) return GREEN;
        if (r <= 9) return YELLOW;
        return RED;
    endfunction

    initial begin
        logic [2:0] lp;
        color       lc [3];
        logic [2:0] exp_s;
        logic [2:0] exp_f;

        Reset = 1'b1;
        Loop1 = 1'b0; Loop2 = 1'b0; Loop3 = 1'b0;
        L1 = RED; L2 = RED; L3 = RED;

        // loop bits are {ch3, ch2, ch1}; s bits are {S3, S2, S1}
        tbl[0]  = mk(3'b001, RED,   RED,   RED,    3'b000);
        tbl[1]  = mk(3'b001, RED,   RED,   RED,    3'b001);
        tbl[2]  = mk(3'b010, RED,   RED,   RED,    3'b001);
        tbl[3]  = mk(3'b000, RED,   RED,   RED,    3'b001);
        tbl[4]  = mk(3'b000, RED,   RED,   RED,    3'b001);
        tbl[5]  = mk(3'b000, GREEN, RED,   RED,    3'b001);
        tbl[6]  = mk(3'b000, GREEN, RED,   RED,    3'b001);
        tbl[7]  = mk(3'b000, GREEN, RED,   RED,    3'b000);
        tbl[8]  = mk(3'b000, GREEN, RED,   RED,    3'b000);
        tbl[9]  = mk(3'b000, GREEN, RED,   RED,    3'b000);
        tbl[10] = mk(3'b100, RED,   RED,   RED,    3'b000);
        tbl[11] = mk(3'b100, RED,   RED,   RED,    3'b100);
        tbl[12] = mk(3'b000, RED,   RED,   GREEN,  3'b100);
        tbl[13] = mk(3'b000, RED,   RED,   GREEN,  3'b100);
        tbl[14] = mk(3'b000, RED,   RED,   YELLOW, 3'b100);
        tbl[15] = mk(3'b000, RED,   RED,   RED,    3'b100);
        tbl[16] = mk(3'b000, RED,   RED,   GREEN,  3'b100);
        tbl[17] = mk(3'b000, RED,   RED,   GREEN,  3'b100);
        tbl[18] = mk(3'b000, RED,   RED,   GREEN,  3'b000);
        tbl[19] = mk(3'b010, RED,   RED,   RED,    3'b000);
        tbl[20] = mk(3'b010, RED,   RED,   RED,    3'b010);
        tbl[21] = mk(3'b000, RED,   GREEN, RED,    3'b010);
        tbl[22] = mk(3'b010, RED,   GREEN, RED,    3'b010);
        tbl[23] = mk(3'b010, RED,   GREEN, RED,    3'b010);
        tbl[24] = mk(3'b000, RED,   GREEN, RED,    3'b000);

        @(negedge Clock);
        @(negedge Clock);
        check("reset S", {1'b0, S3, S2, S1}, 4'h0);
        check("reset Fault", {1'b0, Fault}, 4'h0);
        Reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            apply(tbl[i].loop, tbl[i].l1, tbl[i].l2, tbl[i].l3);
            check($sformatf("table S row %0d", i), {1'b0, S3, S2, S1}, {1'b0, tbl[i].s});
            check($sformatf("table Fault row %0d", i), {1'b0, Fault}, 4'h0);
        end

        // FLASH override with Loop1 still high
        apply(3'b011, RED, RED, RED);
        check("flash pre arm", {1'b0, S3, S2, S1}, 4'h0);
        apply(3'b011, RED, RED, RED);
        check("flash pre call", {1'b0, S3, S2, S1}, 4'h3);
        for (int i = 0; i < 4; i++) begin
            apply(3'b001, FLASH, FLASH, FLASH);
            check($sformatf("flash cycle %0d", i), {1'b0, S3, S2, S1}, 4'h0);
        end
        apply(3'b001, RED, RED, RED);
        check("post flash rearm", {1'b0, S3, S2, S1}, 4'h0);
        apply(3'b001, RED, RED, RED);
        check("post flash call", {1'b0, S3, S2, S1}, 4'h1);

        // Asynchronous reset in the middle of a cycle
        #2 Reset = 1'b1;
        #1;
        check("async reset S", {1'b0, S3, S2, S1}, 4'h0);
        check("async reset Fault", {1'b0, Fault}, 4'h0);
        @(negedge Clock);
        Reset = 1'b0;
        apply(3'b001, RED, RED, RED);
        check("after reset arm", {1'b0, S3, S2, S1}, 4'h0);
        apply(3'b001, RED, RED, RED);
        check("after reset call", {1'b0, S3, S2, S1}, 4'h1);

        // Loop2 held high under GREEN long enough to look stuck
        do_reset();
        for (int i = 0; i < 12; i++) begin
            apply(3'b010, RED, GREEN, RED);
            check($sformatf("stuck S2 edge %0d", i + 1), {3'b000, S2}, {3'b000, (i >= 1)});
`ifdef STUCK_DETECT_EN
            check($sformatf("stuck Fault edge %0d", i + 1), {1'b0, Fault}, {1'b0, 1'b0, (i >= 9), 1'b0});
`else
            check($sformatf("stuck Fault edge %0d", i + 1), {1'b0, Fault}, 4'h0);
`endif
        end
        apply(3'b000, RED, GREEN, RED);
        check("stuck release S2", {3'b000, S2}, 4'h0);
        check("stuck release Fault", {1'b0, Fault}, 4'h0);

        // Random traffic against the model
        do_reset();
        model_clear();
        lp = 3'b000;
        lc[0] = RED; lc[1] = RED; lc[2] = RED;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int ch = 0; ch < 3; ch++) begin
                if ($urandom_range(0, 3) == 0) lp[ch] = ~lp[ch];
                if ($urandom_range(0, 5) == 0) lc[ch] = rand_color();
            end
            apply(lp, lc[0], lc[1], lc[2]);
            for (int ch = 0; ch < 3; ch++) begin
                model_step(ch, lp[ch], lc[ch]);
                exp_s[ch] = (call[ch] || fm[ch]) && !fl[ch];
                exp_f[ch] = fm[ch];
            end
            check($sformatf("random S cyc %0d", cyc), {1'b0, S3, S2, S1}, {1'b0, exp_s});
            check($sformatf("random Fault cyc %0d", cyc), {1'b0, Fault}, {1'b0, exp_f});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
